// File: rtl/lcd_num_fmt_pkg.sv
// lcd_num_fmt_pkg: LCD geometry, ASCII codes, formatter states and
// small helpers shared by the number formatter and its BCD core.
package lcd_num_fmt_pkg;

    localparam int LCD_COLS     = 16;
    localparam int LCD_ROW_BITS = 128;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2
    } fmt_state_e;

    // Decimal digits needed for the largest w-bit value.
    function automatic int dec_digits(input int w);
        longint unsigned m;
        int n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m != 64'd0) begin
                n++;
                m = m / 64'd10;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_ZERO + {4'h0, n};
        return ASCII_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/lcd_num_fmt_dd_bin2bcd.sv
// dd_bin2bcd: sequential double-dabble, one bit per clock.
// The first shift happens at load, so WIDTH shifts finish in WIDTH cycles.
module dd_bin2bcd #(
    parameter int WIDTH = 16,
    parameter int NB    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WIDTH-1:0] bin,
    output logic            busy,
    output logic            bcd_valid,
    output logic [4*NB-1:0] bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic [4*NB-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign busy = (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q      <= '0;
            cnt_q     <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (start && !busy) begin
                // A zero accumulator never needs the add-3 step.
                bcd       <= {{(4*NB-1){1'b0}}, bin[WIDTH-1]};
                sh_q      <= bin << 1;
                cnt_q     <= CNT_INIT;
                bcd_valid <= (WIDTH == 1);
            end else if (busy) begin
                {bcd, sh_q} <= {adj, sh_q} << 1;
                cnt_q       <= cnt_q - CW'(1);
                bcd_valid   <= (cnt_q == CW'(1));
            end
        end
    end

endmodule

// File: rtl/lcd_num_fmt.sv
// lcd_num_fmt: binary value -> right-aligned decimal ASCII on LCD row 0.
// Define LCD_NUM_FMT_HEX_ROW_EN to show the value in hex on row 1.
module lcd_num_fmt
    import lcd_num_fmt_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter logic [8*(LCD_COLS-DIGITS)-1:0] LABEL = "Count:     ",
    parameter logic [LCD_ROW_BITS-1:0] ROW1 = "   IceZUM LCD   "
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        value,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [LCD_ROW_BITS-1:0] msg_0,
    output logic [LCD_ROW_BITS-1:0] msg_1
);

    localparam int NB = dec_digits(WIDTH);
    localparam int ND = (NB > DIGITS) ? NB : DIGITS;

    function automatic logic [8*DIGITS-1:0] zero_field();
        logic [8*DIGITS-1:0] f;
        f = {DIGITS{ASCII_SPACE}};
        f[7:0] = ASCII_ZERO;
        return f;
    endfunction

    localparam logic [LCD_ROW_BITS-1:0] RST_ROW0 = {LABEL, zero_field()};

    fmt_state_e state_q, state_d;

    logic                start;
    logic                wr;
    logic                dd_busy;
    logic                dd_valid;
    logic [4*NB-1:0]     bcd;
    logic [4*ND-1:0]     bcd_pad;
    logic [8*DIGITS-1:0] field;
    logic                ovf;
    logic                seen;
    logic [3:0]          dig;

    dd_bin2bcd #(
        .WIDTH (WIDTH),
        .NB    (NB)
    ) u_dd (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (value),
        .busy      (dd_busy),
        .bcd_valid (dd_valid),
        .bcd       (bcd)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load && !dd_busy) begin
                    start   = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (dd_valid)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // Blank leading zeros; any digit beyond the field forces all stars.
    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*NB-1:0] = bcd;
        ovf = 1'b0;
        for (int i = DIGITS; i < ND; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0)
                ovf = 1'b1;
        end
        seen  = 1'b0;
        dig   = 4'd0;
        field = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig  = bcd_pad[4*i +: 4];
            seen = seen | (dig != 4'd0);
            if (ovf)
                field[8*i +: 8] = ASCII_STAR;
            else if (seen || i == 0)
                field[8*i +: 8] = ASCII_ZERO | {4'h0, dig};
            else
                field[8*i +: 8] = ASCII_SPACE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
            msg_0   <= RST_ROW0;
        end else begin
            state_q <= state_d;
            done    <= wr;
            if (wr)
                msg_0 <= {LABEL, field};
        end
    end

`ifdef LCD_NUM_FMT_HEX_ROW_EN
    localparam int HD = (WIDTH + 3) / 4;

    function automatic logic [LCD_ROW_BITS-1:0] hex_row(
        input logic [WIDTH-1:0] v
    );
        logic [4*HD-1:0] p;
        logic [LCD_ROW_BITS-1:0] r;
        p = '0;
        p[WIDTH-1:0] = v;
        r = {LCD_COLS{ASCII_SPACE}};
        r[127 -: 56] = "Hex: 0x";
        for (int i = 0; i < HD; i++)
            r[127 - 8*(7+i) -: 8] = hex_char(p[4*(HD-1-i) +: 4]);
        return r;
    endfunction

    logic [WIDTH-1:0] val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            msg_1 <= hex_row('0);
        end else begin
            if (start)
                val_q <= value;
            if (wr)
                msg_1 <= hex_row(val_q);
        end
    end
`else
    assign msg_1 = ROW1;
`endif

endmodule
